// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: valid/ready operand and result bus for pipelined_adder.
// The ovf signal exists only when ADDER_OVF_FLAG_EN is defined.
interface pipelined_adder_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef ADDER_OVF_FLAG_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
`ifdef ADDER_OVF_FLAG_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
`ifdef ADDER_OVF_FLAG_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit a+b+cin split into STAGES registered carry chunks with valid/ready flow.
// Define ADDER_OVF_FLAG_EN to add the signed-overflow output ovf.
module pipelined_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input logic               clk,
    input logic               rst_n,
    pipelined_adder_if.slave  bus
);
    localparam int CHUNK = WIDTH / STAGES;

    logic [STAGES-1:0] en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int BW = WIDTH - k * CHUNK;
        // r holds summed low chunks and the still-unsummed high chunks of a
        logic [WIDTH-1:0] r_i, r_n, rq;
        logic [BW-1:0]    b_i;
        logic [CHUNK:0]   add;
        logic             c_i, vin, vq, cq;
        if (k == 0) begin : g_head
            assign r_i = bus.a;
            assign b_i = bus.b;
            assign c_i = bus.cin;
            assign vin = bus.in_valid;
        end else begin : g_tail
            assign r_i = g_stage[k-1].rq;
            assign b_i = g_stage[k-1].g_mid.bq;
            assign c_i = g_stage[k-1].cq;
            assign vin = g_stage[k-1].vq;
        end
        assign add = {1'b0, r_i[k*CHUNK +: CHUNK]} + {1'b0, b_i[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_i};
        always_comb begin
            r_n = r_i;
            r_n[k*CHUNK +: CHUNK] = add[CHUNK-1:0];
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) vq <= 1'b0;
            else if (en[k]) vq <= vin;
        end
        if (k < STAGES - 1) begin : g_mid
            logic [BW-CHUNK-1:0] bq;
            assign en[k] = !vq | en[k+1];
            always_ff @(posedge clk) begin
                if (en[k] & vin) begin
                    rq <= r_n;
                    cq <= add[CHUNK];
                    bq <= b_i[BW-1:CHUNK];
                end
            end
        end else begin : g_last
            assign en[k] = !vq | bus.out_ready;
`ifdef ADDER_OVF_FLAG_EN
            logic ovq;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) ovq <= 1'b0;
                else if (en[k] & vin) ovq <= (r_i[WIDTH-1] == b_i[CHUNK-1]) & (r_n[WIDTH-1] != r_i[WIDTH-1]);
            end
`endif
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rq <= '0;
                    cq <= 1'b0;
                end else if (en[k] & vin) begin
                    rq <= r_n;
                    cq <= add[CHUNK];
                end
            end
        end
    end

    assign bus.in_ready  = en[0];
    assign bus.out_valid = g_stage[STAGES-1].vq;
    assign bus.sum       = g_stage[STAGES-1].rq;
    assign bus.cout      = g_stage[STAGES-1].cq;
`ifdef ADDER_OVF_FLAG_EN
    assign bus.ovf       = g_stage[STAGES-1].g_last.ovq;
`endif
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed checks on an 8-bit/2-stage adder and a randomised 64-bit/4-stage run.
module tb_pipelined_adder;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    pipelined_adder_if #(.WIDTH(8))  ia ();
    pipelined_adder_if #(.WIDTH(64)) ib ();

    pipelined_adder #(.WIDTH(8),  .STAGES(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
    pipelined_adder #(.WIDTH(64), .STAGES(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add_a(input logic [7:0] x, input logic [7:0] y, input logic c,
                         input logic [7:0] es, input logic ec, input logic eo);
        int n;
        @(negedge clk);
        ia.out_ready = 1'b1;
        ia.in_valid  = 1'b1;
        ia.a = x; ia.b = y; ia.cin = c;
        #1 check("single_in_ready", ia.in_ready, 1);
        @(negedge clk);
        ia.in_valid = 1'b0;
        n = 1;
        while (!ia.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("single_latency", n, 2);
        check("single_sum", ia.sum, es);
        check("single_cout", ia.cout, ec);
`ifdef ADDER_OVF_FLAG_EN
        check("single_ovf", ia.ovf, eo);
`else
        if (eo === 1'bx) $display("note: unknown ovf expectation");
`endif
    endtask

    logic [7:0]  ta [10];
    logic [7:0]  tb [10];
    logic        tc [10];
    logic [8:0]  te [10];
    logic [7:0]  held;
    logic [64:0] q [$];

    initial begin
        int tx, rx, n, sent, got;
        logic pending;
        rst_n = 1'b0;
        ia.in_valid = 0; ia.a = 0; ia.b = 0; ia.cin = 0; ia.out_ready = 0;
        ib.in_valid = 0; ib.a = 0; ib.b = 0; ib.cin = 0; ib.out_ready = 0;
        #12;
        check("rst_out_valid", ia.out_valid, 0);
        check("rst_sum", ia.sum, 0);
        check("rst_cout", ia.cout, 0);
        check("rst_in_ready", ia.in_ready, 1);
        check("rst_b_out_valid", ib.out_valid, 0);
`ifdef ADDER_OVF_FLAG_EN
        check("rst_ovf", ia.ovf, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // back-to-back pair: 94+23 then 126+31+1
        @(negedge clk);
        ia.out_ready = 1; ia.in_valid = 1; ia.a = 94; ia.b = 23; ia.cin = 0;
        #1 check("t1_in_ready", ia.in_ready, 1);
        @(negedge clk);
        check("t1_not_yet", ia.out_valid, 0);
        ia.a = 126; ia.b = 31; ia.cin = 1;
        @(negedge clk);
        check("t1_valid", ia.out_valid, 1);
        check("t1_sum", ia.sum, 117);
        check("t1_cout", ia.cout, 0);
        ia.in_valid = 0;
        @(negedge clk);
        check("t2_valid", ia.out_valid, 1);
        check("t2_sum", ia.sum, 158);
        check("t2_cout", ia.cout, 0);
        @(negedge clk);
        check("t2_one_cycle", ia.out_valid, 0);

        add_a(8'd255, 8'd1,   1'b0, 8'd0,   1'b1, 1'b0);
        add_a(8'd255, 8'd255, 1'b1, 8'd255, 1'b1, 1'b0);
        add_a(8'd127, 8'd1,   1'b0, 8'd128, 1'b0, 1'b1);
        add_a(8'd128, 8'd128, 1'b0, 8'd0,   1'b1, 1'b1);

        // streaming with a 5-cycle downstream stall
        for (int i = 0; i < 10; i++) begin
            ta[i] = 8'(i * 29 + 200);
            tb[i] = 8'(i * 17 + 40);
            tc[i] = i[0];
            te[i] = {1'b0, ta[i]} + {1'b0, tb[i]} + {8'd0, tc[i]};
        end
        tx = 0; rx = 0; held = 0;
        for (int cyc = 0; cyc < 60 && rx < 10; cyc++) begin
            @(negedge clk);
            ia.out_ready = !(cyc >= 4 && cyc < 9);
            if (cyc == 4) held = ia.sum;
            if (cyc > 4 && cyc < 9) begin
                check("stall_hold", ia.sum, held);
                check("stall_valid", ia.out_valid, 1);
            end
            if (cyc == 8) check("stall_in_ready", ia.in_ready, 0);
            ia.in_valid = tx < 10;
            ia.a   = tx < 10 ? ta[tx] : 8'd0;
            ia.b   = tx < 10 ? tb[tx] : 8'd0;
            ia.cin = tx < 10 ? tc[tx] : 1'b0;
            #1;
            if (ia.out_valid && ia.out_ready) begin
                check("stream", {ia.cout, ia.sum}, te[rx]);
                rx++;
            end
            if (ia.in_valid && ia.in_ready) tx++;
        end
        ia.in_valid = 0;
        check("stream_count", rx, 10);

        // reset with two tokens in flight
        @(negedge clk);
        ia.out_ready = 1; ia.in_valid = 1; ia.a = 10; ia.b = 20; ia.cin = 0;
        @(negedge clk);
        ia.a = 30; ia.b = 40; ia.cin = 1;
        @(negedge clk);
        ia.in_valid = 0;
        check("pre_rst_sum", ia.sum, 30);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", ia.out_valid, 0);
        check("mid_rst_sum", ia.sum, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_quiet", ia.out_valid, 0);
        end
        add_a(8'd5, 8'd6, 1'b0, 8'd11, 1'b0, 1'b0);

        // 64-bit, 4 stages: latency then randomised traffic
        @(negedge clk);
        ib.out_ready = 1; ib.in_valid = 1; ib.a = '1; ib.b = 64'd1; ib.cin = 0;
        @(negedge clk);
        ib.in_valid = 0;
        n = 1;
        while (!ib.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("w64_latency", n, 4);
        check("w64_wrap", {ib.cout, ib.sum}, 65'h1_0000_0000_0000_0000);
        @(negedge clk);

        sent = 0; got = 0; pending = 0;
        for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
            @(negedge clk);
            ib.out_ready = $urandom_range(3) != 0;
            if (!pending) begin
                ib.in_valid = sent < 1000 && $urandom_range(3) != 0;
                ib.a   = {$urandom, $urandom};
                ib.b   = {$urandom, $urandom};
                ib.cin = 1'($urandom_range(1));
            end
            #1;
            if (ib.out_valid && ib.out_ready) begin
                if (q.size() > 0) check("rand", {ib.cout, ib.sum}, q.pop_front());
                else check("rand_queue", q.size(), 1);
                got++;
            end
            if (ib.in_valid && ib.in_ready) begin
                q.push_back({1'b0, ib.a} + {1'b0, ib.b} + {64'd0, ib.cin});
                sent++;
                pending = 0;
            end else begin
                pending = ib.in_valid;
            end
        end
        ib.in_valid = 0;
        check("rand_count", got, 1000);
        check("rand_left", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
